// File: rtl/iis_rx_ctrl_if.sv
// iis_rx_ctrl_if: control, receiver and FIFO signals between the I2S capture
// controller and its environment.
// The master modport is the controller side. The slave modport is the
// environment side, which drives the requests and the receiver/FIFO status.
interface iis_rx_ctrl_if;
  logic        i_start;
  logic        i_stop;
  logic        i_clr_ovr;
  logic        i_sdata_valid;
  logic [15:0] i_sdata;
  logic        i_fifo_full;
  logic        o_sck;
  logic        o_ws;
  logic        o_rx_en;
  logic        o_fifo_wr;
  logic [15:0] o_fifo_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;
  logic [15:0] o_word_cnt;

  modport master (
    input  i_start, i_stop, i_clr_ovr, i_sdata_valid, i_sdata, i_fifo_full,
    output o_sck, o_ws, o_rx_en, o_fifo_wr, o_fifo_wdata, o_busy, o_done,
    output o_overrun, o_word_cnt
  );

  modport slave (
    output i_start, i_stop, i_clr_ovr, i_sdata_valid, i_sdata, i_fifo_full,
    input  o_sck, o_ws, o_rx_en, o_fifo_wr, o_fifo_wdata, o_busy, o_done,
    input  o_overrun, o_word_cnt
  );
endinterface

// File: rtl/iis_rx_ctrl.sv
// iis_rx_ctrl: I2S receive capture controller.
// The controller generates sck and ws, waits one full frame before it enables
// the receiver, and forwards each received word to a FIFO until a block of
// BLOCK_LEN words has been written or the capture is stopped.
// After the last word it keeps the clocks running to the end of the frame,
// then pulses done.
// Optional feature: define IIS_RX_CTRL_OVR_EN to enable the sticky overrun flag.
// Without that macro, dropped words are discarded silently and o_overrun stays 0.
// All outputs are registered.
module iis_rx_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 16,
  parameter int BLOCK_LEN = 1024
) (
  input  logic          clk,
  input  logic          rst,
  iis_rx_ctrl_if.master bus
);

  localparam int               BIT_W    = $clog2(2 * WORD_BITS);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * WORD_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(WORD_BITS);
  localparam logic [15:0]      CNT_LAST = 16'(BLOCK_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [7:0]       r_div;
  logic [BIT_W-1:0] r_bit;
  logic             r_sck;
  logic             r_ws;
  logic             r_rx_en;
  logic             r_fifo_wr;
  logic [15:0]      r_fifo_wdata;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;
  logic [15:0]      r_word_cnt;

  state_t           w_state_nxt;
  logic [7:0]       w_div_nxt;
  logic [BIT_W-1:0] w_bit_nxt;
  logic             w_sck_nxt;
  logic             w_ws_nxt;
  logic [15:0]      w_cnt_nxt;
  logic [15:0]      w_wdata_nxt;
  logic             w_ovr_nxt;
  logic             w_clk_on;
  logic             w_tick;
  logic             w_fall;
  logic             w_wrap;
  logic             w_accept;

  // The divider wraps once per sck half-period. A falling sck edge advances
  // the bit counter. A wrap of the bit counter marks a frame boundary.
  assign w_tick   = (r_div == DIV_LAST);
  assign w_fall   = w_tick & r_sck;
  assign w_wrap   = w_fall & (r_bit == BIT_LAST);
  assign w_accept = (r_state == S_RUN) & bus.i_sdata_valid & ~bus.i_fifo_full;

  // Next-state logic of the capture sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_state_nxt = S_SYNC;
        else             w_state_nxt = S_IDLE;
      end
      S_SYNC: begin
        if (bus.i_stop)  w_state_nxt = S_DONE;
        else if (w_wrap) w_state_nxt = S_RUN;
        else             w_state_nxt = S_SYNC;
      end
      S_RUN: begin
        if (bus.i_stop || (w_accept && (r_word_cnt == CNT_LAST))) w_state_nxt = S_DRAIN;
        else                                                     w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (w_wrap) w_state_nxt = S_DONE;
        else        w_state_nxt = S_DRAIN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the clock generator, word counter and write data
  always_comb begin
    w_clk_on  = (w_state_nxt == S_SYNC) || (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    w_div_nxt = 8'd0;
    w_bit_nxt = '0;
    w_sck_nxt = 1'b0;
    w_ws_nxt  = 1'b0;
    if (r_state == S_IDLE) begin
      // A new block starts on the left slot with all counters at zero.
      w_ws_nxt = w_clk_on;
    end else if (w_clk_on) begin
      w_div_nxt = w_tick ? 8'd0 : (r_div + 8'd1);
      w_sck_nxt = w_tick ? ~r_sck : r_sck;
      w_bit_nxt = w_fall ? (w_wrap ? '0 : (r_bit + BIT_W'(1))) : r_bit;
      w_ws_nxt  = w_fall ? (w_bit_nxt < SLOT_LEN) : r_ws;
    end else begin
      // DONE and IDLE: sck, ws and both counters are held at zero.
      w_ws_nxt = 1'b0;
    end
    if ((r_state == S_IDLE) && bus.i_start) w_cnt_nxt = 16'd0;
    else if (w_accept)                      w_cnt_nxt = r_word_cnt + 16'd1;
    else                                    w_cnt_nxt = r_word_cnt;
    w_wdata_nxt = w_accept ? bus.i_sdata : r_fifo_wdata;
  end

`ifdef IIS_RX_CTRL_OVR_EN
  logic w_drop;
  assign w_drop = (r_state == S_RUN) & bus.i_sdata_valid & bus.i_fifo_full;

  // Sticky overrun: a dropped word takes priority over a simultaneous clear
  always_comb begin
    if (w_drop)             w_ovr_nxt = 1'b1;
    else if (bus.i_clr_ovr) w_ovr_nxt = 1'b0;
    else                    w_ovr_nxt = r_overrun;
  end
`else
  assign w_ovr_nxt = 1'b0;
`endif

  // State and output registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_div        <= 8'd0;
      r_bit        <= '0;
      r_sck        <= 1'b0;
      r_ws         <= 1'b0;
      r_rx_en      <= 1'b0;
      r_fifo_wr    <= 1'b0;
      r_fifo_wdata <= 16'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_word_cnt   <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_bit        <= w_bit_nxt;
      r_sck        <= w_sck_nxt;
      r_ws         <= w_ws_nxt;
      r_rx_en      <= (w_state_nxt == S_RUN);
      r_fifo_wr    <= w_accept;
      r_fifo_wdata <= w_wdata_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
      r_overrun    <= w_ovr_nxt;
      r_word_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.o_sck        = r_sck;
  assign bus.o_ws         = r_ws;
  assign bus.o_rx_en      = r_rx_en;
  assign bus.o_fifo_wr    = r_fifo_wr;
  assign bus.o_fifo_wdata = r_fifo_wdata;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_overrun    = r_overrun;
  assign bus.o_word_cnt   = r_word_cnt;

endmodule

// File: doc/iis_rx_ctrl.md
IIS_RX_CTRL -- requirements
Module: iis_rx_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: clk cycles per sck half-period, legal range 2..255.
REQ-002 The block SHALL have parameter WORD_BITS, default 16: bits per channel slot, one slot per ws level.
REQ-003 The block SHALL have parameter BLOCK_LEN, default 1024: words written per capture block, legal range 1..65535.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a capture block; honoured only in IDLE.
REQ-007 stop  in  1  one-cycle request to abort capture; honoured in SYNC and RUN.
REQ-008 clr_ovr  in  1  clears sticky overrun.
REQ-009 sdata_valid  in  1  receiver word strobe, one cycle per completed word.
REQ-010 sdata  in  16  receiver word, valid with sdata_valid.
REQ-011 fifo_full  in  1  downstream FIFO cannot accept a write this cycle.
REQ-012 sck  out  1  generated I2S bit clock.
REQ-013 ws  out  1  generated word select; 1 = left slot, 0 = right slot.
REQ-014 rx_en  out  1  receiver enable.
REQ-015 fifo_wr  out  1  FIFO write strobe.
REQ-016 fifo_wdata  out  16  FIFO write data.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 overrun  out  1  sticky dropped-word flag.
REQ-020 word_cnt  out  16  words written in the current block.

Function
REQ-021 States: IDLE, SYNC, RUN, DRAIN, DONE.
REQ-022 IDLE: sck=0, ws=0, rx_en=0, div and bit counters held at 0; start -> SYNC on the next clk.
REQ-023 Clock generation in SYNC, RUN and DRAIN: div counter counts 0..CLK_DIV-1; on wrap, sck toggles.
REQ-024 On each sck falling toggle, the bit counter advances modulo 2*WORD_BITS.
REQ-025 ws SHALL be 1 while the bit counter is 0..WORD_BITS-1 and 0 otherwise, updated in the same cycle as the falling toggle.
REQ-026 SYNC: after one complete frame, i.e. the bit counter wraps to 0 once, the block SHALL move to RUN with rx_en=1 from the first RUN cycle.
REQ-027 RUN: for each sdata_valid with fifo_full=0, assert fifo_wr for exactly one cycle on the next clk, with fifo_wdata=sdata, and increment word_cnt.
REQ-028 RUN: an sdata_valid with fifo_full=1 SHALL produce no write and no word_cnt increment.
REQ-029 RUN -> DRAIN when word_cnt reaches BLOCK_LEN (same cycle as the final write) or when stop is seen.
REQ-030 DRAIN: rx_en=0; clocks keep running until the bit counter next wraps to 0; then -> DONE.
REQ-031 DRAIN: any sdata_valid SHALL be ignored.
REQ-032 DONE: sck=0, ws=0, done=1 for exactly one cycle; -> IDLE; word_cnt holds its final value until the next start, which clears it.
REQ-033 SYNC + stop: -> DONE directly.
REQ-034 start outside IDLE SHALL be ignored.
REQ-035 start and stop in the same IDLE cycle: start wins, stop ignored.
REQ-036 clr_ovr and an overrun event in the same cycle: the set wins.
REQ-037 Latency: sdata_valid to fifo_wr SHALL be exactly 1 clk.

Reset
REQ-038 rst SHALL force IDLE asynchronously, regardless of current state.
REQ-039 On rst, all outputs, counters and fifo_wdata SHALL be 0, including in mid-capture.
REQ-040 The first state transition after rst deassertion SHALL require a new start.

Configuration
REQ-041 Macro IIS_RX_CTRL_OVR_EN defined: a word dropped per REQ-028 sets overrun; clr_ovr clears it.
REQ-042 Macro IIS_RX_CTRL_OVR_EN undefined: overrun SHALL be constant 0, clr_ovr SHALL be ignored, and dropping still occurs.

Verification
REQ-043 Clock check: CLK_DIV=4, WORD_BITS=16, start -> sck period 8 clk; ws period 256 clk; ws high 128 clk; rx_en rises 256 clk after leaving IDLE (±1 clk).
REQ-044 Block completion: BLOCK_LEN=4, four sdata_valid with sdata 0x1111..0x4444, fifo_full=0 -> four fifo_wr each 1 clk later with matching data; word_cnt=4; DRAIN to the frame end; single done pulse.
REQ-045 Overflow with IIS_RX_CTRL_OVR_EN defined: fifo_full=1 during the 2nd of 3 words -> 2 writes, word_cnt=2, overrun=1; clr_ovr -> overrun=0.
REQ-046 Overflow with IIS_RX_CTRL_OVR_EN undefined: same stimulus as REQ-045 -> 2 writes, overrun stays 0.
REQ-047 Abort: stop in RUN after 5 words (BLOCK_LEN=1024) -> rx_en=0 next clk, done at the frame end, word_cnt=5; stop in SYNC -> done next clk, no rx_en.
REQ-048 Reset: rst asserted mid-RUN -> all outputs 0 immediately; start ignored while rst=1; a normal block after release.
